// File: rtl/lut_config_loader_pkg.sv
// Shared types and size helpers for the LUT config chain.
// State encoding plus FRAME_W / CNT_W derivations.
package lut_config_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic int frame_w(input int inputs);
    return 2 * (1 << inputs) + 1;
  endfunction

  function automatic int cnt_w(input int fw);
    return $clog2(fw + 1);
  endfunction

endpackage

// File: rtl/lut_config_loader_if.sv
// Config-loader bus: serial bitstream in, frame/strobes out.
// master drives start/cdata_in/cvalid; slave is the loader.
interface lut_config_loader_if #(
  parameter int FRAME_W = 33
);

  logic               start;
  logic               cdata_in;
  logic               cvalid;
  logic               cready;
  logic               cdata_out;
  logic [FRAME_W-1:0] config_out;
  logic               cen;
  logic               done;
  logic               busy;

  modport master (
    output start, cdata_in, cvalid,
    input  cready, cdata_out, config_out,
    input  cen, done, busy
  );

  modport slave (
    input  start, cdata_in, cvalid,
    output cready, cdata_out, config_out,
    output cen, done, busy
  );

endinterface

// File: rtl/lut_config_loader_cfg_shift_reg.sv
// W-bit MSB-first shift register with shift enable.
// Ports: clk, rst, en, din -> q (parallel), sout (q MSB).
module cfg_shift_reg #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q,
  output logic         sout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= {q[W-2:0], din};
    end
  end

  assign sout = q[W-1];

endmodule

// File: rtl/lut_config_loader.sv
// Serial-to-parallel loader for the fracturable LUT config frame.
// Ports: cclk, rst, cfg (slave bus: bitstream in, frame/cen/done out).
module lut_config_loader
  import lut_config_loader_pkg::*;
#(
  parameter int INPUTS   = 4,
  parameter int MEM_SIZE = 2 ** INPUTS,
  parameter int FRAME_W  = 2 * MEM_SIZE + 1,
  parameter int CNT_W    = cnt_w(FRAME_W)
) (
  input  logic          cclk,
  input  logic          rst,
  lut_config_loader_if.slave cfg
);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [FRAME_W-1:0] cfg_q;
  logic [FRAME_W-1:0] shreg;
  logic               sout;
  logic               accept;
  logic               last_bit;

  // start wins over a coincident bit
  assign accept   = cfg.cvalid
                  & (state_q == ST_SHIFT)
                  & ~cfg.start;
  assign last_bit = accept
                  & (cnt_q == CNT_W'(FRAME_W - 1));

  cfg_shift_reg #(
    .W (FRAME_W)
  ) u_shreg (
    .clk  (cclk),
    .rst  (rst),
    .en   (accept),
    .din  (cfg.cdata_in),
    .q    (shreg),
    .sout (sout)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cfg.cready = 1'b0;
    cfg.cen    = 1'b0;
    cfg.done   = 1'b0;
    cfg.busy   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg.start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        cfg.cready = 1'b1;
        cfg.busy   = 1'b1;
        if (cfg.start) begin
          cnt_d = '0;
        end else if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (last_bit) begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        cfg.cen  = 1'b1;
        cfg.busy = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        cfg.done = 1'b1;
        if (cfg.start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame is taken on the edge that accepts the last
  // bit, so fold that bit in alongside the old shreg.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      cfg_q <= '0;
    end else if (last_bit) begin
      cfg_q <= {shreg[FRAME_W-2:0], cfg.cdata_in};
    end
  end

  assign cfg.config_out = cfg_q;
  assign cfg.cdata_out  = sout;

endmodule

// File: tb/tb_lut_config_loader.sv
// Bench for lut_config_loader: two chained loaders,
// bit-history model, per-cycle compare plus literal pins.
module tb_lut_config_loader;

  localparam int FW = 33;

  logic cclk = 1'b0;
  logic rst  = 1'b1;
  int checks   = 0;
  int failures = 0;
  int cen_cnt  = 0;

  always #5 cclk = ~cclk;

  lut_config_loader_if #(.FRAME_W(FW)) ua ();
  lut_config_loader_if #(.FRAME_W(FW)) ub ();

  assign ub.start    = ua.start;
  assign ub.cvalid   = ua.cvalid;
  assign ub.cdata_in = ua.cdata_out;

  lut_config_loader dut_a (
    .cclk (cclk),
    .rst  (rst),
    .cfg  (ua)
  );

  lut_config_loader dut_b (
    .cclk (cclk),
    .rst  (rst),
    .cfg  (ub)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // model: mode 0 idle, 1 loading, 2 strobe, 3 done
  int mode = 0;
  int nacc = 0;
  bit ha[$];
  bit hb[$];
  logic [FW-1:0] m_cfg_a = '0;
  logic [FW-1:0] m_cfg_b = '0;

  function automatic logic [FW-1:0] tail(input bit q[$]);
    logic [FW-1:0] r;
    int n;
    r = '0;
    n = q.size();
    for (int i = 0; i < FW; i++)
      if (n - 1 - i >= 0) r[i] = q[n-1-i];
    return r;
  endfunction

  function automatic bit sout_of(input bit q[$]);
    if (q.size() >= FW) return q[q.size()-FW];
    return 1'b0;
  endfunction

  always @(posedge cclk or posedge rst) begin
    if (rst) begin
      mode = 0;
      nacc = 0;
      ha.delete();
      hb.delete();
      m_cfg_a = '0;
      m_cfg_b = '0;
    end else begin
      case (mode)
        0: if (ua.start) begin
          mode = 1;
          nacc = 0;
        end
        1: if (ua.start) begin
          nacc = 0;
        end else if (ua.cvalid) begin
          hb.push_back(sout_of(ha));
          ha.push_back(ua.cdata_in);
          nacc++;
          if (nacc == FW) begin
            mode = 2;
            m_cfg_a = tail(ha);
            m_cfg_b = tail(hb);
          end
        end
        2: mode = 3;
        default: if (ua.start) begin
          mode = 1;
          nacc = 0;
        end
      endcase
    end
  end

  always @(negedge cclk) begin
    if (ua.cen) cen_cnt++;
    chk("a_cfg", 64'(ua.config_out), 64'(m_cfg_a));
    chk("a_cen", 64'(ua.cen), 64'(mode == 2));
    chk("a_done", 64'(ua.done), 64'(mode == 3));
    chk("a_busy", 64'(ua.busy),
        64'(mode == 1 || mode == 2));
    chk("a_cready", 64'(ua.cready), 64'(mode == 1));
    chk("a_sout", 64'(ua.cdata_out), 64'(sout_of(ha)));
    chk("b_cfg", 64'(ub.config_out), 64'(m_cfg_b));
    chk("b_cen", 64'(ub.cen), 64'(mode == 2));
    chk("b_sout", 64'(ub.cdata_out), 64'(sout_of(hb)));
  end

  task automatic step(input logic s,
                      input logic v,
                      input logic d);
    @(negedge cclk);
    ua.start    = s;
    ua.cvalid   = v;
    ua.cdata_in = d;
  endtask

  // returns on the cycle cen should be high
  task automatic load(input logic [FW-1:0] f,
                      input bit stall);
    step(1'b1, 1'b0, 1'b0);
    for (int i = FW - 1; i >= 0; i--) begin
      if (stall) step(1'b0, 1'b0, ~f[i]);
      step(1'b0, 1'b1, f[i]);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [1:0] lut_eval(
    input logic [FW-1:0] c,
    input logic [7:0] a);
    if (c[FW-1])
      return {c[16 + a[7:4]], c[a[3:0]]};
    return {1'b0, a[4] ? c[16 + a[3:0]] : c[a[3:0]]};
  endfunction

  logic [7:0] addrs [6];
  logic [1:0] lo;
  int c0;

  initial begin
    ua.start    = 1'b0;
    ua.cvalid   = 1'b0;
    ua.cdata_in = 1'b0;
    addrs = '{8'h00, 8'hE0, 8'hF0, 8'hFF, 8'h7F, 8'hFE};

    repeat (2) @(negedge cclk);
    chk("rst_cfg", 64'(ua.config_out), 64'(0));
    chk("rst_cready", 64'(ua.cready), 64'(0));
    chk("rst_busy", 64'(ua.busy), 64'(0));
    chk("rst_sout", 64'(ua.cdata_out), 64'(0));
    rst = 1'b0;

    // continuous stream
    load(33'h1_5555_5555, 1'b0);
    chk("t1_cfg", 64'(ua.config_out), 64'(33'h1_5555_5555));
    chk("t1_cen", 64'(ua.cen), 64'(1));
    step(1'b0, 1'b0, 1'b0);
    chk("t1_cen_off", 64'(ua.cen), 64'(0));
    chk("t1_done", 64'(ua.done), 64'(1));

    // stalls every other cycle
    c0 = cen_cnt;
    load(33'h1_5555_5555, 1'b1);
    chk("t2_cfg", 64'(ua.config_out), 64'(33'h1_5555_5555));
    chk("t2_cen", 64'(ua.cen), 64'(1));
    step(1'b0, 1'b0, 1'b0);
    chk("t2_one_cen", 64'(cen_cnt - c0), 64'(1));

    // abort after 10 bits, then a full frame
    c0 = cen_cnt;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 1'(i % 2));
    load(33'h0_0000_FFFF, 1'b0);
    chk("t3_cfg", 64'(ua.config_out), 64'(33'h0_0000_FFFF));
    step(1'b0, 1'b0, 1'b0);
    chk("t3_one_cen", 64'(cen_cnt - c0), 64'(1));

    // reset in the middle of a load
    load(33'h1_0000_0001, 1'b0);
    chk("t4_cfg", 64'(ua.config_out), 64'(33'h1_0000_0001));
    step(1'b0, 1'b0, 1'b0);
    c0 = cen_cnt;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_cfg", 64'(ua.config_out), 64'(0));
    chk("t4_rst_cready", 64'(ua.cready), 64'(0));
    chk("t4_rst_busy", 64'(ua.busy), 64'(0));
    chk("t4_rst_done", 64'(ua.done), 64'(0));
    step(1'b0, 1'b0, 1'b0);
    chk("t4_no_cen", 64'(cen_cnt - c0), 64'(0));
    rst = 1'b0;

    // daisy chain: b ends up with a's first frame
    load(33'h1_2345_6789, 1'b0);
    chk("t5_b_first", 64'(ub.config_out), 64'(0));
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("t5_sout_msb", 64'(ua.cdata_out), 64'(1));
    load(33'h0_DEAD_BEEF, 1'b0);
    chk("t5_a_cfg", 64'(ua.config_out), 64'(33'h0_DEAD_BEEF));
    chk("t5_b_cfg", 64'(ub.config_out), 64'(33'h1_2345_6789));
    step(1'b0, 1'b0, 1'b0);

    // fractured LUT, both halves 16'h8000
    load({1'b1, 16'h8000, 16'h8000}, 1'b0);
    chk("t6_split", 64'(ua.config_out[FW-1]), 64'(1));
    for (int k = 0; k < 6; k++) begin
      lo = lut_eval(ua.config_out, addrs[k]);
      chk("t6_out1", 64'(lo[1]),
          64'(addrs[k][7:4] == 4'hF));
      chk("t6_out0", 64'(lo[0]),
          64'(addrs[k][3:0] == 4'hF));
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/lut_config_loader.md
Name: lut_config_loader

Overview:
- Serial-to-parallel configuration loader that sits directly upstream of the fracturable SXX LUT.
- Accepts a bitstream one bit per cycle and assembles a full frame of the form {use_fracture, first_lut, second_lut}.
- Presents the frame on config_out, then pulses cen for exactly one cycle so the LUT captures it.
- Provides a daisy-chain serial output so several loaders can share one bitstream pin.

Parameters:
- INPUTS, 4, LUT input count per half; must match the downstream LUT.
- MEM_SIZE, 2**INPUTS, bits per LUT half.
- FRAME_W, 2*MEM_SIZE+1, frame width; 33 at the defaults.
- CNT_W, $clog2(FRAME_W+1), bit-counter width; 6 at the defaults.

Ports:
- cclk  in  1  configuration clock; every register is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins (or restarts) a frame load.
- cdata_in  in  1  serial config bit, MSB of the frame first.
- cvalid  in  1  cdata_in is valid this cycle.
- cready  out  1  loader accepts a bit this cycle.
- cdata_out  out  1  registered MSB of the shift register, for daisy chaining.
- config_out  out  FRAME_W  parallel frame, drives LUT config_in.
- cen  out  1  one-cycle load strobe to the LUT.
- done  out  1  frame committed; held until the next start or reset.
- busy  out  1  high in SHIFT or COMMIT.

Behaviour:
- Reset (async assert, released synchronously to cclk): state=IDLE, shift register=0, config_out=0, count=0, cready=0, cen=0, done=0, busy=0, cdata_out=0.
- States and transitions:
  - IDLE: start -> SHIFT, count=0, done=0.
  - SHIFT: cready=1. Each cycle with cvalid&cready does shreg <= {shreg[FRAME_W-2:0], cdata_in} and count++. When the accepted bit makes count==FRAME_W, go to COMMIT next cycle. Cycles with cvalid=0 are stalls: nothing changes.
  - COMMIT: config_out <= shreg, captured on the entry edge into COMMIT. cen=1 for this single cycle; config_out is already stable while cen is high. cready=0. Next state is DONE.
  - DONE: done=1, cen=0. start -> SHIFT (done clears); cvalid is ignored.
- Latency: from the cycle the last (FRAME_W-th) bit is accepted, config_out updates and cen asserts on the following cycle. done asserts the cycle after cen.
- First serial bit lands in config_out[FRAME_W-1] (use_fracture). Last bit lands in config_out[0].
- config_out changes only on entry to COMMIT. A partial load never disturbs the previously committed frame.
- start in SHIFT aborts the load: count=0, shreg retained, stays in SHIFT, config_out unchanged, no cen. If start and cvalid coincide, start wins and the bit is dropped.
- start during COMMIT is ignored (the commit always completes); start in DONE is honoured.
- cdata_out = shreg[FRAME_W-1], registered. It shifts only on accepted bits, so chained loaders see the upstream frame delayed by FRAME_W accepted bits.
- count never exceeds FRAME_W; no wrap.
- rst asserted mid-SHIFT or mid-COMMIT: immediate return to reset values, no cen pulse, config_out=0.
- cen is high only in COMMIT and never for two consecutive cycles.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, SHIFT=2'd1, COMMIT=2'd2, DONE=2'd3) and the FRAME_W/CNT_W derivation functions, reused by the CLB-level config chain.
- One natural sub-module, cfg_shift_reg: a parameterised FRAME_W shift register with shift-enable and a serial MSB output. The FSM, counter and commit logic stay in the top.

Test Plan:
- Reset then start, shift 33 bits 1,0,1,0,… with cvalid=1 continuously -> config_out=33'h1_5555_5555 one cycle after the 33rd bit; cen high exactly one cycle; done high the next cycle.
- Same frame with cvalid toggled 1/0 -> identical config_out; cen asserts one cycle after the 33rd accepted bit; count frozen during stalls.
- Start, 10 bits, start again, 33 bits of frame 33'h0_0000_FFFF -> config_out=33'h0_0000_FFFF; exactly one cen pulse total.
- After a commit of 33'h1_0000_0001, start and shift 20 bits, then assert rst -> config_out=0, cen never pulsed, state IDLE, cready=0.
- Two loaders chained (cdata_out -> cdata_in), 66 bits streamed -> the downstream loader commits the first 33 bits; check cdata_out matches the input delayed by 33 accepted bits.
- Drive the loader into a fracturable LUT: a frame with MSB=1 and both halves 16'h8000 -> the LUT split flag is set and out[1]=1 only when the upper address is 4'hF.
